bcd_display_mux: RTL and testbench



---
 rtl/bcd_disp_pkg.sv | 32 +++
 rtl/bcd_seg_decode.sv | 29 ++
 rtl/bcd_display_mux.sv | 152 +++++++++++++++
 tb/tb_bcd_display_mux.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/bcd_disp_pkg.sv
// Shared constants for the seven-segment display path.
// Glyphs are active-high, bit0=a .. bit6=g; pin polarity is applied by the user.
package bcd_disp_pkg;

  localparam int unsigned SEG_W = 7;

  // Segment bit positions
  localparam int unsigned SEG_A = 0;
  localparam int unsigned SEG_B = 1;
  localparam int unsigned SEG_C = 2;
  localparam int unsigned SEG_D = 3;
  localparam int unsigned SEG_E = 4;
  localparam int unsigned SEG_F = 5;
  localparam int unsigned SEG_G = 6;

  // Decimal glyphs (gfedcba)
  localparam logic [SEG_W-1:0] SEG_0 = 7'b011_1111;
  localparam logic [SEG_W-1:0] SEG_1 = 7'b000_0110;
  localparam logic [SEG_W-1:0] SEG_2 = 7'b101_1011;
  localparam logic [SEG_W-1:0] SEG_3 = 7'b100_1111;
  localparam logic [SEG_W-1:0] SEG_4 = 7'b110_0110;
  localparam logic [SEG_W-1:0] SEG_5 = 7'b110_1101;
  localparam logic [SEG_W-1:0] SEG_6 = 7'b111_1101;
  localparam logic [SEG_W-1:0] SEG_7 = 7'b000_0111;
  localparam logic [SEG_W-1:0] SEG_8 = 7'b111_1111;
  localparam logic [SEG_W-1:0] SEG_9 = 7'b110_1111;

  // Non-decimal nibbles show a dash (g only); blank lights nothing
  localparam logic [SEG_W-1:0] SEG_DASH  = SEG_W'(1) << SEG_G;
  localparam logic [SEG_W-1:0] SEG_BLANK = '0;

endpackage

// File: rtl/bcd_seg_decode.sv
// Combinational BCD to seven-segment glyph decoder (active-high).
// Ports:
//   bcd      in  4  BCD nibble
//   glyph_c  out 7  active-high glyph, bit0=a .. bit6=g; 10-15 give a dash
module bcd_seg_decode
  import bcd_disp_pkg::*;
(
  input  logic [3:0]       bcd,
  output logic [SEG_W-1:0] glyph_c
);

  always_comb begin
    glyph_c = SEG_DASH;
    case (bcd)
      4'd0:    glyph_c = SEG_0;
      4'd1:    glyph_c = SEG_1;
      4'd2:    glyph_c = SEG_2;
      4'd3:    glyph_c = SEG_3;
      4'd4:    glyph_c = SEG_4;
      4'd5:    glyph_c = SEG_5;
      4'd6:    glyph_c = SEG_6;
      4'd7:    glyph_c = SEG_7;
      4'd8:    glyph_c = SEG_8;
      4'd9:    glyph_c = SEG_9;
      default: glyph_c = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/bcd_display_mux.sv
// Time-multiplexed driver for a DIGITS-wide seven-segment display.
// Scans one digit per PRESCALE clocks; a loaded BCD word is staged and only
// adopted for display at a frame wrap so a frame never mixes two values.
// Optional feature: define BCD_DISP_LZB_EN for leading-zero blanking.
// Ports:
//   clk         in   1         system clock
//   rst_n       in   1         asynchronous active-low reset
//   bcd_in      in   4*DIGITS  packed BCD, nibble k is digit k
//   load        in   1         strobe: capture bcd_in into staging
//   load_ack    out  1         pulse when the staged value became displayed
//   segment     out  7         segment lines a..g, polarity per ACTIVE_LOW
//   anode       out  DIGITS    one-hot digit enable, polarity per ACTIVE_LOW
//   frame_tick  out  1         pulse in the cycle the scan wraps to digit 0
module bcd_display_mux
  import bcd_disp_pkg::*;
#(
  parameter int unsigned DIGITS     = 4,
  parameter int unsigned PRESCALE   = 50000,
  parameter bit          ACTIVE_LOW = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [4*DIGITS-1:0]   bcd_in,
  input  logic                  load,
  output logic                  load_ack,
  output logic [SEG_W-1:0]      segment,
  output logic [DIGITS-1:0]     anode,
  output logic                  frame_tick
);

  localparam int unsigned BCD_W = 4 * DIGITS;
  localparam int unsigned CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(PRESCALE - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(DIGITS - 1);
  localparam logic [SEG_W-1:0]  SEG_OFF   = {SEG_W{ACTIVE_LOW}};
  localparam logic [DIGITS-1:0] ANODE_OFF = {DIGITS{ACTIVE_LOW}};

  logic [CNT_W-1:0]  presc, presc_nxt;
  logic [IDX_W-1:0]  idx, idx_nxt;
  logic [BCD_W-1:0]  staging, staging_nxt;
  logic [BCD_W-1:0]  display, display_nxt;
  logic              pending, pending_nxt;
  logic              ack_nxt, tick_nxt;
  logic [SEG_W-1:0]  seg_nxt, lit;
  logic [DIGITS-1:0] anode_nxt;
  logic [3:0]        nibble;
  logic [SEG_W-1:0]  glyph_c;
  logic              blank;
  logic              presc_last, wrap;

  // Select the displayed nibble of the digit currently being scanned
  always_comb begin
    nibble = 4'd0;
    for (int k = 0; k < int'(DIGITS); k++) begin
      if (idx == IDX_W'(k)) nibble = display[k*4 +: 4];
    end
  end

  bcd_seg_decode u_decode (
    .bcd     (nibble),
    .glyph_c (glyph_c)
  );

`ifdef BCD_DISP_LZB_EN
  // Blank this digit when it and every digit above it hold zero; digit 0 never blanks
  always_comb begin
    logic higher_nz;
    higher_nz = 1'b0;
    for (int k = 0; k < int'(DIGITS); k++) begin
      if ((IDX_W'(k) >= idx) && (display[k*4 +: 4] != 4'd0)) higher_nz = 1'b1;
    end
    blank = (idx != '0) && !higher_nz;
  end
`else
  assign blank = 1'b0;
`endif

  // Scan counters, double-buffer handshake and next output values
  always_comb begin
    presc_nxt   = presc;
    idx_nxt     = idx;
    staging_nxt = staging;
    display_nxt = display;
    pending_nxt = pending;
    ack_nxt     = 1'b0;
    tick_nxt    = 1'b0;
    seg_nxt     = SEG_OFF;
    anode_nxt   = ANODE_OFF;
    lit         = SEG_BLANK;

    presc_last = (presc == CNT_LAST);
    wrap       = presc_last && (idx == IDX_LAST);

    if (presc_last) begin
      presc_nxt = '0;
      idx_nxt   = (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
    end else begin
      presc_nxt = presc + CNT_W'(1);
    end

    // frame_tick is registered, so flag the wrap one cycle ahead
    tick_nxt = (presc_nxt == CNT_LAST) && (idx_nxt == IDX_LAST);

    // A load in the wrap cycle bypasses staging and commits directly
    if (wrap) begin
      if (load) begin
        staging_nxt = bcd_in;
        display_nxt = bcd_in;
      end else if (pending) begin
        display_nxt = staging;
      end
      ack_nxt     = load || pending;
      pending_nxt = 1'b0;
    end else if (load) begin
      staging_nxt = bcd_in;
      pending_nxt = 1'b1;
    end

    lit     = blank ? SEG_BLANK : glyph_c;
    seg_nxt = ACTIVE_LOW ? ~lit : lit;
    for (int k = 0; k < int'(DIGITS); k++) begin
      anode_nxt[k] = (idx == IDX_W'(k)) ^ ACTIVE_LOW;
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc      <= '0;
      idx        <= '0;
      staging    <= '0;
      display    <= '0;
      pending    <= 1'b0;
      segment    <= SEG_OFF;
      anode      <= ANODE_OFF;
      load_ack   <= 1'b0;
      frame_tick <= 1'b0;
    end else begin
      presc      <= presc_nxt;
      idx        <= idx_nxt;
      staging    <= staging_nxt;
      display    <= display_nxt;
      pending    <= pending_nxt;
      segment    <= seg_nxt;
      anode      <= anode_nxt;
      load_ack   <= ack_nxt;
      frame_tick <= tick_nxt;
    end
  end

endmodule

// File: tb/tb_bcd_display_mux.sv
// Directed self-checking bench for bcd_display_mux.
// Instance a: DIGITS=4, PRESCALE=4, ACTIVE_LOW=1. Instance b: DIGITS=1, PRESCALE=1.
module tb_bcd_display_mux;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, load, load_ack, frame_tick;
  logic [15:0] bcd_in;
  logic [6:0]  segment;
  logic [3:0]  anode;

  logic        rst_n_b, load_b, load_ack_b, frame_tick_b;
  logic [3:0]  bcd_b;
  logic [6:0]  segment_b;
  logic [0:0]  anode_b;

  int errors = 0;
  int checks = 0;

  bcd_display_mux #(.DIGITS(4), .PRESCALE(4), .ACTIVE_LOW(1'b1)) dut_a (
    .clk        (clk),
    .rst_n      (rst_n),
    .bcd_in     (bcd_in),
    .load       (load),
    .load_ack   (load_ack),
    .segment    (segment),
    .anode      (anode),
    .frame_tick (frame_tick)
  );

  bcd_display_mux #(.DIGITS(1), .PRESCALE(1), .ACTIVE_LOW(1'b1)) dut_b (
    .clk        (clk),
    .rst_n      (rst_n_b),
    .bcd_in     (bcd_b),
    .load       (load_b),
    .load_ack   (load_ack_b),
    .segment    (segment_b),
    .anode      (anode_b),
    .frame_tick (frame_tick_b)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Pin-level (active-low) glyphs, hand inverted from the gfedcba patterns
  function automatic logic [6:0] pin_glyph(input logic [3:0] n);
    case (n)
      4'd0: return 7'h40;
      4'd1: return 7'h79;
      4'd2: return 7'h24;
      4'd3: return 7'h30;
      4'd4: return 7'h19;
      4'd5: return 7'h12;
      4'd6: return 7'h02;
      4'd7: return 7'h78;
      4'd8: return 7'h00;
      4'd9: return 7'h10;
      default: return 7'h3F;
    endcase
  endfunction

  function automatic logic [6:0] exp_seg(input logic [15:0] w, input int d);
    logic [15:0] sh;
    sh = w >> (4 * d);
`ifdef BCD_DISP_LZB_EN
    if (d > 0 && sh == 16'h0) return 7'h7F;
`endif
    return pin_glyph(sh[3:0]);
  endfunction

  // Step one full frame (16 clocks) from a frame boundary, checking every cycle.
  // ldN is the step at which a load strobe is driven (-1: none).
  task automatic run_frame(input string tag, input logic [15:0] word,
                           input int ld1, input logic [15:0] v1,
                           input int ld2, input logic [15:0] v2,
                           input bit exp_ack);
    for (int s = 1; s <= 16; s++) begin
      logic [3:0] an;
      int d;
      @(negedge clk);
      d = (s - 1) / 4;
      an = 4'hF;
      an[d] = 1'b0;
      chk($sformatf("%s s%0d anode", tag, s), 16'(anode), 16'(an));
      chk($sformatf("%s s%0d segment", tag, s), 16'(segment), 16'(exp_seg(word, d)));
      chk($sformatf("%s s%0d frame_tick", tag, s), 16'(frame_tick), 16'(s == 15));
      chk($sformatf("%s s%0d load_ack", tag, s), 16'(load_ack), 16'(s == 16 && exp_ack));
      load = 1'b0;
      if (s == ld1) begin load = 1'b1; bcd_in = v1; end
      if (s == ld2) begin load = 1'b1; bcd_in = v2; end
    end
  endtask

  initial begin
    rst_n = 1'b0; load = 1'b0; bcd_in = 16'h0;
    rst_n_b = 1'b0; load_b = 1'b0; bcd_b = 4'h0;
    repeat (3) @(negedge clk);
    chk("rst segment", 16'(segment), 16'h7F);
    chk("rst anode", 16'(anode), 16'hF);
    chk("rst load_ack", 16'(load_ack), 16'h0);
    chk("rst frame_tick", 16'(frame_tick), 16'h0);
    chk("rst_b anode", 16'(anode_b), 16'h1);

    // Release and load 1234 immediately; first frame still shows 0000
    rst_n = 1'b1; load = 1'b1; bcd_in = 16'h1234;
    run_frame("f0_zero", 16'h0000, -1, 16'h0, -1, 16'h0, 1'b1);
    run_frame("f1_1234", 16'h1234, 3, 16'h5678, 5, 16'h9999, 1'b1);
    run_frame("f2_9999", 16'h9999, 15, 16'h0042, -1, 16'h0, 1'b1);
    run_frame("f3_0042", 16'h0042, -1, 16'h0, -1, 16'h0, 1'b0);
    run_frame("f4_0042", 16'h0042, 8, 16'h3C21, -1, 16'h0, 1'b1);
    run_frame("f5_3C21", 16'h3C21, -1, 16'h0, -1, 16'h0, 1'b0);

    // Mid-digit reset with a load pending
    load = 1'b1; bcd_in = 16'h7777;
    @(negedge clk);
    load = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst segment", 16'(segment), 16'h7F);
    chk("mid_rst anode", 16'(anode), 16'hF);
    chk("mid_rst load_ack", 16'(load_ack), 16'h0);
    chk("mid_rst frame_tick", 16'(frame_tick), 16'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run_frame("f6_after_rst", 16'h0000, -1, 16'h0, -1, 16'h0, 1'b0);

    // Single digit, PRESCALE=1: wraps every cycle
    rst_n_b = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      chk($sformatf("b c%0d anode", c), 16'(anode_b), 16'h0);
      chk($sformatf("b c%0d frame_tick", c), 16'(frame_tick_b), 16'h1);
      chk($sformatf("b c%0d segment", c), 16'(segment_b), 16'h40);
      chk($sformatf("b c%0d load_ack", c), 16'(load_ack_b), 16'h0);
    end
    load_b = 1'b1; bcd_b = 4'd5;
    @(negedge clk);
    load_b = 1'b0;
    chk("b ack", 16'(load_ack_b), 16'h1);
    chk("b seg_before", 16'(segment_b), 16'h40);
    @(negedge clk);
    chk("b ack_single", 16'(load_ack_b), 16'h0);
    chk("b seg_5", 16'(segment_b), 16'h12);
    chk("b frame_tick_hold", 16'(frame_tick_b), 16'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
